// File: rtl/i2s_tx.sv
// Stereo I2S transmitter: derives MCLK/SCK/LRCK from an 11-bit frame counter
// and serializes one buffered left/right pair per frame onto sdout.
module i2s_tx #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_left,
    input  logic [WIDTH-1:0] in_right,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             mclk,
    output logic             sck,
    output logic             lrck,
    output logic             sdout,
    output logic             underrun
);

    localparam logic [5:0] WIDTH_SLOTS = 6'(WIDTH);

    logic [10:0]      cnt;
    logic             hold_full;
    logic [WIDTH-1:0] hold_l, hold_r;
    logic [WIDTH-1:0] frame_l, frame_r;
    logic             sdout_q, underrun_q;

    logic             load, xfer, slot_end;
    logic [5:0]       next_slot;
    logic [4:0]       next_pos;
    logic [WIDTH-1:0] word, shifted;
    logic             next_bit;

    assign load      = (cnt == 11'd2047);
    assign xfer      = in_valid & ~hold_full;
    assign slot_end  = (cnt[4:0] == 5'd31);
    assign next_slot = cnt[10:5] + 6'd1;
    assign next_pos  = next_slot[4:0];

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking (=) here would make results depend on statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 11'd1;
        end
    end

    // A full hold register is drained on the load edge, so xfer cannot coincide with it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_full <= 1'b0;
        end else if (load && hold_full) begin
            hold_full <= 1'b0;
        end else if (xfer) begin
            hold_full <= 1'b1;
        end
    end

    // NOTE: the hold data is a storage register qualified by hold_full, so it
    // needs no reset; only the flag that marks it valid is reset.
    always_ff @(posedge clk) begin
        if (xfer) begin
            hold_l <= in_left;
            hold_r <= in_right;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_l    <= '0;
            frame_r    <= '0;
            underrun_q <= 1'b0;
        end else begin
            underrun_q <= load & ~hold_full;
            if (load) begin
                frame_l <= hold_full ? hold_l : '0;
                frame_r <= hold_full ? hold_r : '0;
            end
        end
    end

    // Bit for the slot that starts at the next sck falling edge: slot position p
    // (1..WIDTH within a half) carries word[WIDTH-p], i.e. MSB one slot after lrck flips.
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        next_bit = 1'b0;
        word     = next_slot[5] ? frame_r : frame_l;
        shifted  = word << (next_pos - 5'd1);
        if (next_pos != 5'd0 && {1'b0, next_pos} <= WIDTH_SLOTS) begin
            next_bit = shifted[WIDTH-1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sdout_q <= 1'b0;
        end else if (slot_end) begin
            sdout_q <= next_bit;
        end
    end

    assign in_ready = ~hold_full;
    assign mclk     = cnt[2];
    assign sck      = cnt[4];
    assign lrck     = cnt[10];
    assign sdout    = sdout_q;
    assign underrun = underrun_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Directed bench for i2s_tx: clock ratios, reset, single pair, underrun,
// load-edge transfer, back-pressure stream, and a 24-bit instance.
module tb_i2s_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] in_left = '0, in_right = '0;
    logic        in_valid = 1'b0;
    logic        in_ready, mclk, sck, lrck, sdout, underrun;

    logic [23:0] in_left24 = '0, in_right24 = '0;
    logic        in_valid24 = 1'b0;
    logic        in_ready24, mclk24, sck24, lrck24, sdout24, underrun24;

    i2s_tx #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .in_left(in_left), .in_right(in_right),
        .in_valid(in_valid), .in_ready(in_ready), .mclk(mclk), .sck(sck),
        .lrck(lrck), .sdout(sdout), .underrun(underrun)
    );

    i2s_tx #(.WIDTH(24)) dut24 (
        .clk(clk), .rst(rst), .in_left(in_left24), .in_right(in_right24),
        .in_valid(in_valid24), .in_ready(in_ready24), .mclk(mclk24), .sck(sck24),
        .lrck(lrck24), .sdout(sdout24), .underrun(underrun24)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc   = 0;
    logic [10:0] c;
    logic [63:0] cur_bits, last_bits, cur_bits24, last_bits24;
    int          cur_ur, last_ur, cur_xfers, last_xfers, cur_rdy, last_rdy;
    bit          stream_on = 1'b0;
    int          stream_n  = 0;
    logic [31:0] pairs_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected slot map: slot k (1..w) = L[w-k], slot 32+k = R[w-k], rest 0.
    function automatic logic [63:0] exp_bits(input logic [31:0] l, input logic [31:0] r, input int w);
        logic [63:0] b = '0;
        for (int k = 1; k <= w; k++) begin
            b[k]      = l[w-k];
            b[32 + k] = r[w-k];
        end
        return b;
    endfunction

    task automatic clear_frame();
        cur_bits = '0; cur_bits24 = '0;
        cur_ur = 0; cur_xfers = 0; cur_rdy = 0;
    endtask

    task automatic tick();
        bit xfer;
        xfer = in_valid && in_ready;
        @(posedge clk);
        #1;
        cyc++;
        c = 11'(cyc);
        if (c == 11'd0) begin
            last_bits = cur_bits; last_bits24 = cur_bits24;
            last_ur = cur_ur; last_xfers = cur_xfers; last_rdy = cur_rdy;
            clear_frame();
        end
        if (underrun) begin
            cur_ur++;
            check("underrun_at_cnt0", 64'(c), 64'd0);
        end
        if (xfer) begin
            cur_xfers++;
            if (stream_on) begin
                pairs_q.push_back({in_left, in_right});
                stream_n++;
                in_left  = 16'h1100 + 16'(stream_n);
                in_right = 16'hEE00 + 16'(stream_n);
            end
        end
        if (stream_on && in_ready) cur_rdy++;
        if (c[4:0] == 5'd16) begin
            cur_bits[c[10:5]]   = sdout;
            cur_bits24[c[10:5]] = sdout24;
        end
    endtask

    task automatic to_wrap();
        int i = 0;
        do begin
            tick();
            i++;
        end while (c != 11'd0 && i < 2100);
        if (c != 11'd0) check("wrap_timeout", 64'(c), 64'd0);
    endtask

    task automatic check_rises();
        int r_m = -1, r_s = -1, r_l = -1;
        for (int i = 0; i < 1100; i++) begin
            tick();
            if (mclk && r_m < 0) r_m = cyc;
            if (sck  && r_s < 0) r_s = cyc;
            if (lrck && r_l < 0) r_l = cyc;
        end
        check("mclk_first_rise", 64'(r_m), 64'd4);
        check("sck_first_rise",  64'(r_s), 64'd16);
        check("lrck_first_rise", 64'(r_l), 64'd1024);
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        check("outputs_held_in_reset", {58'd0, mclk, sck, lrck, sdout, underrun, in_ready}, 64'b000001);
        #2 rst = 1'b1;
        cyc = 0;
        clear_frame();
    endtask

    initial begin
        clear_frame();
        last_bits = '0; last_bits24 = '0;
        last_ur = 0; last_xfers = 0; last_rdy = 0;

        #1;
        check("reset_outputs", {58'd0, mclk, sck, lrck, sdout, underrun, in_ready}, 64'b000001);
        release_reset();
        check_rises();

        // Single pair before the first wrap, plus the 24-bit instance.
        in_left = 16'hA5C3; in_right = 16'h0001; in_valid = 1'b1;
        in_left24 = 24'h800001; in_right24 = 24'h000000; in_valid24 = 1'b1;
        tick();
        in_valid = 1'b0; in_valid24 = 1'b0;
        check("ready_low_after_accept", 64'(in_ready), 64'd0);
        to_wrap();
        check("reset_frame_zero", last_bits, 64'd0);
        check("no_underrun_first_load", 64'(underrun), 64'd0);
        to_wrap();
        check("single_pair_bits", last_bits, exp_bits(32'h0000A5C3, 32'h00000001, 16));
        check("single_pair_no_underrun", 64'(last_ur), 64'd0);
        check("width24_bits", last_bits24, exp_bits(32'h00800001, 32'h0, 24));
        check("width24_slots25_31_zero", 64'(last_bits24[31:25]), 64'd0);

        // Empty frame.
        to_wrap();
        check("underrun_frame_bits", last_bits, 64'd0);
        check("underrun_pulse_count", 64'(last_ur), 64'd1);

        // Transfer exactly on the 2047->0 load edge.
        while (c != 11'd2047) tick();
        in_left = 16'h7FFF; in_right = 16'h8000; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("load_edge_underrun", 64'(underrun), 64'd1);
        check("load_edge_hold_full", 64'(in_ready), 64'd0);
        tick();
        check("underrun_one_clk", 64'(underrun), 64'd0);
        to_wrap();
        check("load_edge_frame_zero", last_bits, 64'd0);
        check("load_edge_frame_underrun", 64'(last_ur), 64'd1);
        to_wrap();
        check("load_edge_next_frame", last_bits, exp_bits(32'h00007FFF, 32'h00008000, 16));
        check("load_edge_next_no_underrun", 64'(last_ur), 64'd0);

        // Back-pressure stream with in_valid held high.
        stream_on = 1'b1;
        stream_n  = 0;
        in_left = 16'h1100; in_right = 16'hEE00; in_valid = 1'b1;
        for (int i = 0; i <= 8; i++) begin
            to_wrap();
            if (i >= 1) begin
                logic [31:0] p;
                p = (pairs_q.size() > 0) ? pairs_q.pop_front() : 32'hDEAD_BEEF;
                check($sformatf("stream_bits_%0d", i), last_bits, exp_bits({16'd0, p[31:16]}, {16'd0, p[15:0]}, 16));
                check($sformatf("stream_xfers_%0d", i), 64'(last_xfers), 64'd1);
                check($sformatf("stream_ready_cycles_%0d", i), 64'(last_rdy), 64'd1);
                check($sformatf("stream_underrun_%0d", i), 64'(last_ur), 64'd0);
            end
        end
        in_valid = 1'b0;
        stream_on = 1'b0;

        // Mid-frame reset at cnt = 700 with hold full.
        tick();
        in_left = 16'hFFFF; in_right = 16'hFFFF; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        while (c != 11'd700) tick();
        check("pre_reset_clocks", {60'd0, mclk, sck, lrck, in_ready}, 64'b1100);
        rst = 1'b0;
        #1;
        check("midrun_reset_outputs", {58'd0, mclk, sck, lrck, sdout, underrun, in_ready}, 64'b000001);
        release_reset();
        check_rises();
        to_wrap();
        check("post_reset_frame_zero", last_bits, 64'd0);
        check("post_reset_silent", 64'(last_ur), 64'd0);
        check("post_reset_empty_underrun", 64'(underrun), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
